// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter sharing one 3-bit sign-magnitude multiplier between NREQ requesters.
// Optional completed-operation counter enabled by defining MULT_SHARE_STATS_EN.

module multiplication (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  output logic [4:0] product_o,
  output logic       zf_o,
  output logic       sf_o
);
  logic [3:0] mag;

  assign mag       = {2'b00, a_i[1:0]} * {2'b00, b_i[1:0]};
  assign product_o = {a_i[2] ^ b_i[2], mag};
  assign zf_o      = (mag == 4'd0);
  assign sf_o      = product_o[4] & ~zf_o;
endmodule

module mult_share_ctrl #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_a,
  input  logic [3*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [4:0]        rsp_product,
  output logic              rsp_zf,
  output logic              rsp_sf,
  output logic              busy,
  output logic [15:0]       op_count
);
  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // a requester holds valid (operands may change) until it sees ready, and the response
  // holds rsp_* stable while rsp_valid is high until rsp_ready is seen.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [2:0]      op_a_q, op_b_q;
  logic [IDW-1:0]  id_q;
  logic            rsp_valid_q, rsp_zf_q, rsp_sf_q, busy_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [4:0]      rsp_product_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx, rr_next;
  logic [2:0]      sel_a, sel_b;
  logic            found;
  logic [4:0]      mul_product;
  logic            mul_zf, mul_sf;

  // Search starts at rr_ptr and wraps, so the last-served requester has lowest priority.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    sel_a = '0;
    sel_b = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = IDW'(idx);
        sel_a      = req_a[3*idx +: 3];
        sel_b      = req_b[3*idx +: 3];
        found      = 1'b1;
      end
    end
    if (state_q != S_IDLE || rst) grant = '0;
  end

  assign rr_next = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);

  multiplication u_mult (
    .a_i       (op_a_q),
    .b_i       (op_b_q),
    .product_o (mul_product),
    .zf_o      (mul_zf),
    .sf_o      (mul_sf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      id_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_zf_q      <= 1'b0;
      rsp_sf_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|grant) begin
            op_a_q   <= sel_a;
            op_b_q   <= sel_b;
            id_q     <= gidx;
            rr_ptr_q <= rr_next;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rsp_product_q <= mul_product;
          rsp_zf_q      <= mul_zf;
          rsp_sf_q      <= mul_sf;
          rsp_id_q      <= id_q;
          rsp_valid_q   <= 1'b1;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = grant;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign rsp_zf      = rsp_zf_q;
  assign rsp_sf      = rsp_sf_q;
  assign busy        = busy_q;

`ifdef MULT_SHARE_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_valid_q && rsp_ready && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a response scoreboard fed at each accepted request.

module tb_mult_share_ctrl;
  localparam int NREQ = 2;
  localparam int IDW  = 2;
  localparam int EW   = IDW + 7;

`ifdef MULT_SHARE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [4:0]        rsp_product;
  logic              rsp_zf, rsp_sf, busy;
  logic [15:0]       op_count;

  int checks = 0;
  int errors = 0;
  int n_hs   = 0;
  int rr_m   = 0;
  logic [EW-1:0] exp_q[$];
  int grant_log[$];

  mult_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_zf      (rsp_zf),
    .rsp_sf      (rsp_sf),
    .busy        (busy),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {product[4:0], zf, sf} from the sign-magnitude definition.
  function automatic logic [6:0] model(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] m;
    logic s, z;
    m = {2'b00, a[1:0]} * {2'b00, b[1:0]};
    s = a[2] ^ b[2];
    z = (m == 4'd0);
    return {s, m, z, s & ~z};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  // Observe the handshakes that the next rising edge will take, then move to the next falling edge.
  task automatic cyc();
    int g;
    logic [NREQ-1:0] eg;
    logic [EW-1:0] e;
    #1;
    if (!rst && (req_ready & req_valid) != '0) begin
      g = rr_pick(req_valid, rr_m);
      eg = '0;
      eg[g] = 1'b1;
      check("grant", req_ready, eg);
      exp_q.push_back({IDW'(g), model(req_a[3*g +: 3], req_b[3*g +: 3])});
      grant_log.push_back(g);
      rr_m = (g + 1) % NREQ;
    end
    if (!rst && rsp_valid && rsp_ready) begin
      n_hs++;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rsp_scoreboard", {rsp_id, rsp_product, rsp_zf, rsp_sf}, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_op(input int idx, input logic [2:0] a, input logic [2:0] b,
                       input logic [6:0] exp_pzs);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[3*idx +: 3] = a;
    req_b[3*idx +: 3] = b;
    rsp_ready = 1'b1;
    cyc();
    check("issue_rsp_valid", rsp_valid, 0);
    check("issue_busy", busy, 1);
    req_valid = '0;
    cyc();
    check("resp_valid", rsp_valid, 1);
    check("resp_value", {rsp_product, rsp_zf, rsp_sf}, exp_pzs);
    check("resp_id", rsp_id, idx);
    cyc();
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_id, rsp_product, rsp_zf, rsp_sf}, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single op 3*3, then sign from requester 1
    do_op(0, 3'b011, 3'b011, 7'b01001_0_0);
    do_op(1, 3'b110, 3'b011, 7'b10110_0_1);

    // round robin with both requesters held and operands changing before accept
    grant_log.delete();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 40 && grant_log.size() < 4; c++) begin
      req_a = 6'($urandom_range(0, 63));
      req_b = 6'($urandom_range(0, 63));
      cyc();
    end
    req_valid = '0;
    check("rr_count", grant_log.size(), 4);
    for (int k = 0; k < grant_log.size() && k < 4; k++) check("rr_order", grant_log[k], k % 2);
    for (int c = 0; c < 10 && busy; c++) cyc();
    check("rr_drain_busy", busy, 0);
    check("rr_drain_queue", exp_q.size(), 0);

    // backpressure: hold response five cycles with other requests pending
    req_valid = 2'b01;
    req_a[2:0] = 3'b001;
    req_b[2:0] = 3'b110;
    rsp_ready = 1'b0;
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", {rsp_valid, busy, req_ready, rsp_id, rsp_product, rsp_zf, rsp_sf},
            {1'b1, 1'b1, 2'b00, 2'd0, 7'b10010_0_1});
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc();
    check("bp_release_busy", busy, 0);
    check("bp_release_valid", rsp_valid, 0);

    // zero and negative-zero
    do_op(0, 3'b100, 3'b001, 7'b10000_1_0);
    do_op(1, 3'b000, 3'b111, 7'b10000_1_0);
    check("op_count_before_rst", op_count, STATS ? n_hs : 0);

    // reset while ISSUE: the in-flight result must vanish
    req_valid = 2'b01;
    req_a[2:0] = 3'b011;
    req_b[2:0] = 3'b010;
    cyc();
    req_valid = '0;
    check("mid_issue_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {rsp_valid, busy, req_ready, rsp_id, rsp_product, rsp_zf, rsp_sf}, 0);
    check("mid_rst_op_count", op_count, 0);
    exp_q.delete();
    rr_m = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("post_rst_quiet", {rsp_valid, busy}, 0);
    end
    do_op(1, 3'b111, 3'b111, 7'b01001_0_0);
    check("op_count_after_rst", op_count, STATS ? 1 : 0);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
